// File: rtl/fifo_prog.sv
// fifo_prog: single-clock FIFO with selectable read mode (first-word-fall-through or
// registered), runtime almost-full/almost-empty thresholds, synchronous flush,
// pass-through when full and sticky overflow/underflow flags.
module fifo_prog #(
  parameter int unsigned p_WORD_LEN  = 8,
  parameter int unsigned p_FIFO_SIZE = 8,
  parameter bit          p_FWFT      = 1'b1,
  localparam int unsigned p_ADDR_LEN = $clog2(p_FIFO_SIZE)
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_flush,
  input  logic [p_WORD_LEN-1:0] i_enq_data,
  input  logic                  i_enq_en,
  output logic                  o_enq_rdy,
  input  logic                  i_deq_en,
  output logic                  o_deq_rdy,
  output logic [p_WORD_LEN-1:0] o_out_data,
  output logic                  o_out_valid,
  output logic [p_ADDR_LEN:0]   o_len,
  output logic                  o_full,
  output logic                  o_empty,
  input  logic [p_ADDR_LEN:0]   i_afull_thr,
  input  logic [p_ADDR_LEN:0]   i_aempty_thr,
  output logic                  o_afull,
  output logic                  o_aempty,
  output logic                  o_overflow,
  output logic                  o_underflow,
  input  logic                  i_clr_err
);

  localparam logic [p_ADDR_LEN:0] PtrOne = 1;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [p_ADDR_LEN:0]   head_q, head_d, tail_q, tail_d;
  logic [p_WORD_LEN-1:0] mem [p_FIFO_SIZE];
  logic                  overflow_q, overflow_d, underflow_q, underflow_d;
  logic                  push, pop, wr_en;

  // Occupancy and status decode from the pointer pair.
  always_comb begin
    o_empty   = (head_q == tail_q);
    o_full    = (head_q[p_ADDR_LEN-1:0] == tail_q[p_ADDR_LEN-1:0]) &&
                (head_q[p_ADDR_LEN] != tail_q[p_ADDR_LEN]);
    o_len     = head_q - tail_q;
    o_enq_rdy = !o_full;
    o_deq_rdy = !o_empty;
    o_afull   = (o_len >= i_afull_thr);
    o_aempty  = (o_len <= i_aempty_thr);
  end

  // Accept decode; a pop frees the slot a full FIFO needs, so push+pop passes through.
  always_comb begin
    pop   = i_deq_en && !o_empty;
    push  = i_enq_en && (!o_full || (i_deq_en && o_deq_rdy));
    wr_en = push && !i_flush;
  end

  // Pointer and sticky-flag next state; flush drops this cycle's traffic and errors.
  always_comb begin
    head_d      = head_q;
    tail_d      = tail_q;
    overflow_d  = overflow_q && !i_clr_err;
    underflow_d = underflow_q && !i_clr_err;
    if (i_flush) begin
      head_d      = '0;
      tail_d      = '0;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
    end else begin
      if (push) head_d = head_q + PtrOne;
      if (pop)  tail_d = tail_q + PtrOne;
      // A new error beats a simultaneous clear.
      if (i_enq_en && o_full && !pop) overflow_d = 1'b1;
      if (i_deq_en && o_empty)        underflow_d = 1'b1;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      head_q      <= '0;
      tail_q      <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage write; contents are deliberately not cleared by reset.
  always_ff @(posedge i_clk) begin
    if (!i_reset && wr_en) mem[head_q[p_ADDR_LEN-1:0]] <= i_enq_data;
  end

  always_comb begin
    o_overflow  = overflow_q;
    o_underflow = underflow_q;
  end

  if (p_FWFT) begin : g_fwft
    // Head word visible combinationally; all ones while empty.
    always_comb begin
      o_out_valid = !o_empty;
      o_out_data  = o_empty ? '1 : mem[tail_q[p_ADDR_LEN-1:0]];
    end
  end else begin : g_reg
    logic [p_WORD_LEN-1:0] out_data_q;
    logic                  out_valid_q;

    // Registered read: popped word lands one edge later with a one-cycle valid pulse.
    always_ff @(posedge i_clk) begin
      if (i_reset) begin
        out_data_q  <= '0;
        out_valid_q <= 1'b0;
      end else if (i_flush) begin
        out_valid_q <= 1'b0;
      end else begin
        out_valid_q <= pop;
        if (pop) out_data_q <= mem[tail_q[p_ADDR_LEN-1:0]];
      end
    end

    always_comb begin
      o_out_valid = out_valid_q;
      o_out_data  = out_data_q;
    end
  end

endmodule

// File: tb/tb_fifo_prog.sv
// tb_fifo_prog: directed stimulus into a FWFT and a registered-read instance driven in
// parallel; monitors pop expected words from per-instance scoreboards on every output.
module tb_fifo_prog;

  localparam int unsigned W = 8;
  localparam int unsigned N = 8;

  logic         i_clk = 1'b0;
  logic         i_reset, i_flush, i_enq_en, i_deq_en, i_clr_err;
  logic [W-1:0] i_enq_data;
  logic [3:0]   i_afull_thr, i_aempty_thr;

  logic         f_enq_rdy, f_deq_rdy, f_out_valid, f_full, f_empty;
  logic         f_afull, f_aempty, f_overflow, f_underflow;
  logic [W-1:0] f_out_data;
  logic [3:0]   f_len;
  logic         r_enq_rdy, r_deq_rdy, r_out_valid, r_full, r_empty;
  logic         r_afull, r_aempty, r_overflow, r_underflow;
  logic [W-1:0] r_out_data;
  logic [3:0]   r_len;

  int checks = 0;
  int passes = 0;
  logic [W-1:0] exp_f[$];
  logic [W-1:0] exp_r[$];

  always #5 i_clk = ~i_clk;

  fifo_prog #(.p_WORD_LEN(W), .p_FIFO_SIZE(N), .p_FWFT(1'b1)) u_fwft (
    .i_clk(i_clk), .i_reset(i_reset), .i_flush(i_flush), .i_enq_data(i_enq_data),
    .i_enq_en(i_enq_en), .o_enq_rdy(f_enq_rdy), .i_deq_en(i_deq_en), .o_deq_rdy(f_deq_rdy),
    .o_out_data(f_out_data), .o_out_valid(f_out_valid), .o_len(f_len), .o_full(f_full),
    .o_empty(f_empty), .i_afull_thr(i_afull_thr), .i_aempty_thr(i_aempty_thr),
    .o_afull(f_afull), .o_aempty(f_aempty), .o_overflow(f_overflow),
    .o_underflow(f_underflow), .i_clr_err(i_clr_err)
  );

  fifo_prog #(.p_WORD_LEN(W), .p_FIFO_SIZE(N), .p_FWFT(1'b0)) u_reg (
    .i_clk(i_clk), .i_reset(i_reset), .i_flush(i_flush), .i_enq_data(i_enq_data),
    .i_enq_en(i_enq_en), .o_enq_rdy(r_enq_rdy), .i_deq_en(i_deq_en), .o_deq_rdy(r_deq_rdy),
    .o_out_data(r_out_data), .o_out_valid(r_out_valid), .o_len(r_len), .o_full(r_full),
    .o_empty(r_empty), .i_afull_thr(i_afull_thr), .i_aempty_thr(i_aempty_thr),
    .o_afull(r_afull), .o_aempty(r_aempty), .o_overflow(r_overflow),
    .o_underflow(r_underflow), .i_clr_err(i_clr_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // FWFT instance: the word on the bus is consumed whenever a dequeue meets valid.
  always @(negedge i_clk) begin
    if (!i_reset && !i_flush && i_deq_en && f_out_valid) begin
      if (exp_f.size() == 0) check("fwft_unexpected_out", {24'h0, f_out_data}, 32'hFFFF_FFFF);
      else check("fwft_out_data", {24'h0, f_out_data}, {24'h0, exp_f.pop_front()});
    end
  end

  // Registered instance: every valid pulse carries one popped word.
  always @(negedge i_clk) begin
    if (r_out_valid) begin
      if (exp_r.size() == 0) check("reg_unexpected_out", {24'h0, r_out_data}, 32'hFFFF_FFFF);
      else check("reg_out_data", {24'h0, r_out_data}, {24'h0, exp_r.pop_front()});
    end
  end

  task automatic cyc(input logic enq, input logic [W-1:0] d, input logic deq);
    i_enq_en   = enq;
    i_enq_data = d;
    i_deq_en   = deq;
    @(posedge i_clk);
    #1;
    i_enq_en = 1'b0;
    i_deq_en = 1'b0;
    i_flush  = 1'b0;
    i_clr_err = 1'b0;
  endtask

  task automatic expect_word(input logic [W-1:0] d);
    exp_f.push_back(d);
    exp_r.push_back(d);
  endtask

  task automatic fill(input logic [W-1:0] base, input int n, input bit track);
    for (int i = 0; i < n; i++) begin
      if (track) expect_word(base + W'(i));
      cyc(1'b1, base + W'(i), 1'b0);
    end
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b1);
  endtask

  initial begin
    i_reset = 1'b1; i_flush = 1'b0; i_enq_en = 1'b0; i_deq_en = 1'b0; i_clr_err = 1'b0;
    i_enq_data = '0; i_afull_thr = 4'd6; i_aempty_thr = 4'd2;
    repeat (2) @(posedge i_clk);
    #1;
    i_reset = 1'b0;

    // Reset state
    check("rst_len", {28'h0, f_len}, 32'd0);
    check("rst_empty", {31'h0, f_empty}, 32'd1);
    check("rst_full", {31'h0, f_full}, 32'd0);
    check("rst_fwft_valid", {31'h0, f_out_valid}, 32'd0);
    check("rst_fwft_data", {24'h0, f_out_data}, 32'hFF);
    check("rst_reg_valid", {31'h0, r_out_valid}, 32'd0);
    check("rst_reg_data", {24'h0, r_out_data}, 32'h00);
    check("rst_flags", {30'h0, f_overflow, f_underflow}, 32'd0);

    // Fill and drain in order
    fill(8'h10, 8, 1'b1);
    check("t1_full", {31'h0, f_full}, 32'd1);
    check("t1_len", {28'h0, f_len}, 32'd8);
    check("t1_enq_rdy", {31'h0, f_enq_rdy}, 32'd0);
    drain(8);
    check("t1_empty", {31'h0, f_empty}, 32'd1);
    cyc(1'b0, '0, 1'b0);

    // Pass-through while full
    fill(8'h20, 8, 1'b1);
    expect_word(8'hAA);
    cyc(1'b1, 8'hAA, 1'b1);
    check("t2_len", {28'h0, f_len}, 32'd8);
    check("t2_overflow", {31'h0, f_overflow}, 32'd0);
    drain(8);
    check("t2_empty", {31'h0, r_empty}, 32'd1);
    cyc(1'b0, '0, 1'b0);

    // Sticky errors
    cyc(1'b0, '0, 1'b1);
    check("t3_underflow_set", {31'h0, f_underflow}, 32'd1);
    cyc(1'b0, '0, 1'b0);
    check("t3_underflow_sticky", {31'h0, r_underflow}, 32'd1);
    i_clr_err = 1'b1;
    cyc(1'b0, '0, 1'b0);
    check("t3_underflow_clr", {31'h0, f_underflow}, 32'd0);
    i_clr_err = 1'b1;
    cyc(1'b0, '0, 1'b1);
    check("t3_set_wins", {31'h0, f_underflow}, 32'd1);
    fill(8'h30, 8, 1'b1);
    cyc(1'b1, 8'hEE, 1'b0);
    check("t3_overflow", {31'h0, f_overflow}, 32'd1);
    check("t3_ovf_len", {28'h0, f_len}, 32'd8);
    drain(8);
    i_clr_err = 1'b1;
    cyc(1'b0, '0, 1'b0);
    check("t3_flags_clr", {30'h0, r_overflow, r_underflow}, 32'd0);

    // Thresholds
    for (int n = 0; n <= 8; n++) begin
      check("t4_len", {28'h0, f_len}, 32'(n));
      check("t4_aempty", {31'h0, f_aempty}, (n <= 2) ? 32'd1 : 32'd0);
      check("t4_afull", {31'h0, f_afull}, (n >= 6) ? 32'd1 : 32'd0);
      if (n < 8) begin
        expect_word(8'h40 + W'(n));
        cyc(1'b1, 8'h40 + W'(n), 1'b0);
      end
    end
    i_afull_thr = 4'd8;
    #1;
    check("t4_thr8_full", {31'h0, f_afull}, 32'd1);
    drain(1);
    check("t4_thr8_len7", {31'h0, f_afull}, 32'd0);
    drain(7);
    i_afull_thr = 4'd0;
    #1;
    check("t4_thr0_empty", {31'h0, f_afull}, 32'd1);
    i_afull_thr = 4'd6;

    // Read latency per mode
    expect_word(8'h55);
    cyc(1'b1, 8'h55, 1'b0);
    check("t5_fwft_head", {24'h0, f_out_data}, 32'h55);
    check("t5_reg_no_valid", {31'h0, r_out_valid}, 32'd0);
    cyc(1'b0, '0, 1'b1);
    check("t5_reg_valid", {31'h0, r_out_valid}, 32'd1);
    check("t5_reg_data", {24'h0, r_out_data}, 32'h55);
    cyc(1'b0, '0, 1'b0);
    check("t5_reg_pulse_end", {31'h0, r_out_valid}, 32'd0);
    check("t5_reg_hold", {24'h0, r_out_data}, 32'h55);

    // Flush keeps flags, then wrap pointers
    cyc(1'b0, '0, 1'b1);
    fill(8'h60, 5, 1'b0);
    check("t6_len5", {28'h0, f_len}, 32'd5);
    i_flush = 1'b1;
    cyc(1'b1, 8'h99, 1'b0);
    check("t6_flush_len", {28'h0, f_len}, 32'd0);
    check("t6_flush_empty", {31'h0, r_empty}, 32'd1);
    check("t6_flush_flags", {30'h0, f_overflow, f_underflow}, 32'd1);
    check("t6_flush_valid", {30'h0, f_out_valid, r_out_valid}, 32'd0);
    i_clr_err = 1'b1;
    cyc(1'b0, '0, 1'b0);
    fill(8'h70, 3, 1'b1);
    for (int i = 0; i < 20; i++) begin
      expect_word(8'h80 + W'(i));
      cyc(1'b1, 8'h80 + W'(i), 1'b1);
    end
    check("t6_wrap_len", {28'h0, f_len}, 32'd3);
    drain(3);
    cyc(1'b0, '0, 1'b0);
    cyc(1'b0, '0, 1'b0);
    check("t6_wrap_empty", {31'h0, f_empty}, 32'd1);
    check("fwft_sb_drained", 32'(exp_f.size()), 32'd0);
    check("reg_sb_drained", 32'(exp_r.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
